// File: rtl/timer_multi.sv
// Multi-channel prescaled down-counter timer on an 8-bit memory-mapped bus.
// Optional cascading of channel c-1 expiry into channel c when TIMER_CHAIN_EN is defined.

module timer_multi_ch #(
    parameter int WIDTH = 16,
    parameter int IDX   = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sel,
    input  logic [3:0] off,
    input  logic [7:0] wdata,
    input  logic       we,
    input  logic       re,
    input  logic       chain_in,
    output logic       expire,
    output logic [7:0] rdata,
    output logic       pirq
);
    localparam int NB = WIDTH / 8;
    localparam int SW = (WIDTH > 8) ? WIDTH - 8 : 1;
    localparam logic [WIDTH-1:0] ONE = 1;
`ifdef TIMER_CHAIN_EN
    localparam bit CHAIN_OK = (IDX > 0);
`else
    localparam bit CHAIN_OK = 1'b0;
`endif

    logic             en, periodic, int_en, chain, pending;
    logic [3:0]       presc, pcnt;
    logic [WIDTH-1:0] reload, shadow, count;
    logic [SW-1:0]    snap;

    logic             wr, ctrl_wr, stat_wr, commit, start, stop, own_tick, tick;
    logic [WIDTH-1:0] shadow_n, reload_n, cnt_view;
    int               offi;

    always_comb begin
        offi     = int'(off);
        wr       = sel && we;
        ctrl_wr  = wr && (off == 4'h0);
        stat_wr  = wr && (off == 4'h1);
        start    = ctrl_wr && !en && wdata[0];
        stop     = ctrl_wr && en && !wdata[0];
        own_tick = (pcnt == presc);
        // A chained channel ticks on its neighbour's expiry instead of its prescaler.
        tick     = en && !stop && ((CHAIN_OK && chain) ? chain_in : own_tick);
        expire   = tick && (count == '0);
        shadow_n = shadow;
        for (int i = 0; i < NB; i++)
            if (wr && offi == 4 + i) shadow_n[8*i +: 8] = wdata;
        commit   = wr && (offi == 4 + NB - 1);
        reload_n = commit ? shadow_n : reload;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            en       <= 1'b0;
            periodic <= 1'b0;
            int_en   <= 1'b0;
            chain    <= 1'b0;
            presc    <= '0;
            pending  <= 1'b0;
            pcnt     <= '0;
            reload   <= '1;
            shadow   <= '0;
            count    <= '1;
            snap     <= '0;
        end else begin
            shadow <= shadow_n;
            reload <= reload_n;
            if (ctrl_wr) begin
                en       <= wdata[0];
                periodic <= wdata[1];
                int_en   <= wdata[2];
                chain    <= CHAIN_OK & wdata[3];
                presc    <= wdata[7:4];
            end
            if (en && !stop)
                pcnt <= own_tick ? 4'd0 : pcnt + 4'd1;
            if (start) begin
                count <= reload_n;
                pcnt  <= '0;
            end else if (tick) begin
                if (count != '0)   count <= count - ONE;
                else if (periodic) count <= reload;
                else               en    <= 1'b0;
            end
            // Set beats a same-cycle W1C so an expiry is never lost.
            if (expire)                   pending <= 1'b1;
            else if (stat_wr && wdata[0]) pending <= 1'b0;
            if (sel && re && off == 4'h8)
                snap <= SW'(count >> 8);
        end
    end

    assign pirq = pending && int_en;

    always_comb begin
        cnt_view = WIDTH'({snap, count[7:0]});
        rdata    = '0;
        if (off == 4'h0) rdata = {presc, chain, int_en, periodic, en};
        if (off == 4'h1) rdata = {7'd0, pending};
        for (int i = 0; i < NB; i++) begin
            if (offi == 4 + i) rdata = reload[8*i +: 8];
            if (offi == 8 + i) rdata = cnt_view[8*i +: 8];
        end
    end
endmodule

module timer_multi #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [$clog2(CHANNELS)+3:0]   addr,
    input  logic [7:0]                    wdata,
    input  logic                          we,
    input  logic                          re,
    output logic [7:0]                    rdata,
    output logic                          irq
);
    logic [CHANNELS-1:0]      sel, expire, pirq;
    logic [CHANNELS-1:0][7:0] ch_rd;
    int                       chn;

    assign chn = int'(addr) >> 4;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic chain_in;
        if (c == 0) begin : g_first
            assign chain_in = 1'b0;
        end else begin : g_rest
            assign chain_in = expire[c-1];
        end
        assign sel[c] = (chn == c);
        timer_multi_ch #(.WIDTH(WIDTH), .IDX(c)) u_ch (
            .clk      (clk),
            .reset    (reset),
            .sel      (sel[c]),
            .off      (addr[3:0]),
            .wdata    (wdata),
            .we       (we),
            .re       (re),
            .chain_in (chain_in),
            .expire   (expire[c]),
            .rdata    (ch_rd[c]),
            .pirq     (pirq[c])
        );
    end

    // Unpopulated channel indices fall through to zero.
    always_comb begin
        rdata = '0;
        for (int c = 0; c < CHANNELS; c++)
            if (chn == c) rdata = ch_rd[c];
    end

    always_ff @(posedge clk) begin
        if (reset) irq <= 1'b0;
        else       irq <= |pirq;
    end
endmodule

// File: tb/tb_timer_multi.sv
// Directed and randomized checks for timer_multi against expiry-period arithmetic.
module tb_timer_multi;
    localparam int WIDTH = 16, CHANNELS = 2, AW = $clog2(CHANNELS) + 4;

    logic          clk = 1'b0, reset, we, re, irq;
    logic [AW-1:0] addr;
    logic [7:0]    wdata, rdata;
    int            passed = 0, fails = 0, total = 0;

    timer_multi #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) dut (
        .clk(clk), .reset(reset), .addr(addr), .wdata(wdata),
        .we(we), .re(re), .rdata(rdata), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic rd(input int ch, input int off, output int d);
        addr = AW'(ch * 16 + off); #1;
        d = int'(rdata);
    endtask

    task automatic wr(input int ch, input int off, input int v);
        addr = AW'(ch * 16 + off); wdata = 8'(v); we = 1'b1;
        @(posedge clk); #1;
        we = 1'b0;
    endtask

    // Coherent multi-byte count read: byte 0 with re latches the rest.
    task automatic rd_count(input int ch, output int v);
        int hi;
        addr = AW'(ch * 16 + 8); re = 1'b1; #1;
        v = int'(rdata);
        step();
        re = 1'b0;
        rd(ch, 9, hi);
        v = v | (hi << 8);
    endtask

    task automatic wait_pend(input int ch, input int maxc, output int k);
        int d;
        k = 0;
        do begin step(); k++; rd(ch, 1, d); end while (d[0] == 1'b0 && k < maxc);
        chk("pending_seen", d & 1, 1);
    endtask

    // Cycles between the expiry just observed and the next one (first cycle is the W1C).
    task automatic next_expiry(input int ch, output int n);
        int k;
        wr(ch, 1, 1);
        wait_pend(ch, 400, k);
        n = k + 1;
    endtask

    initial begin
        int d, k, n, ch, rl, ps, per, k0;
        reset = 1'b1; we = 1'b0; re = 1'b0; addr = '0; wdata = '0;
        step(); step();
        reset = 1'b0;

        chk("rst_irq", int'(irq), 0);
        for (int c = 0; c < CHANNELS; c++) begin
            rd(c, 0, d); chk("rst_ctrl", d, 0);
            rd(c, 1, d); chk("rst_stat", d, 0);
            rd(c, 2, d); chk("rst_hole", d, 0);
            rd(c, 4, d); chk("rst_rl0", d, 8'hff);
            rd(c, 5, d); chk("rst_rl1", d, 8'hff);
            rd(c, 6, d); chk("rst_rl2_absent", d, 0);
            rd_count(c, d); chk("rst_count", d, 16'hffff);
        end

        // Ch0 periodic, reload 3, presc 0: expiry every 4 cycles, irq one cycle later.
        wr(0, 4, 8'h03); wr(0, 5, 8'h00); wr(0, 0, 8'h07);
        wait_pend(0, 50, k); chk("ch0_first_expiry", k, 4);
        chk("irq_lag", int'(irq), 0);
        step(); chk("irq_rise", int'(irq), 1);
        wr(0, 1, 1);
        rd(0, 1, d); chk("w1c_clears", d, 0);
        step(); chk("irq_drop", int'(irq), 0);
        step(); rd(0, 1, d); chk("re_expiry", d, 1);
        step(); chk("irq_rerise", int'(irq), 1);
        wr(0, 0, 0); wr(0, 1, 1);

        // Ch1 one-shot, reload 2, presc 2: 9 cycles, then disabled at zero.
        wr(1, 4, 8'h02); wr(1, 5, 8'h00); wr(1, 0, 8'h25);
        wait_pend(1, 50, k); chk("ch1_oneshot", k, 9);
        rd(1, 0, d); chk("ch1_en_cleared", d, 8'h24);
        step(); chk("ch1_irq", int'(irq), 1);
        step(); step();
        rd_count(1, d); chk("ch1_count_zero", d, 0);
        wr(1, 1, 1);

        // Low reload byte alone does not commit; high byte does, at the next reload.
        wr(0, 0, 8'h03);
        wr(0, 4, 8'h10);
        wait_pend(0, 50, k); chk("uncommitted_period", k, 3);
        wr(0, 5, 8'h00);
        next_expiry(0, n); chk("old_reload_in_flight", n, 3);
        next_expiry(0, n); chk("new_reload_period", n, 17);
        wr(0, 0, 0); wr(0, 1, 1);

        // Snapshot: byte1 comes from the byte0-read latch, not the live count.
        wr(0, 4, 8'h00); wr(0, 5, 8'h01); wr(0, 0, 8'h01);
        addr = AW'(8); re = 1'b1; #1;
        chk("snap_b0", int'(rdata), 8'h00);
        step(); re = 1'b0;
        step(); step();
        rd(0, 9, d); chk("snap_b1", d, 8'h01);
        rd(0, 8, d); chk("live_b0", d, 8'hfd);
        wr(0, 0, 0);

        // Chain bit.
        wr(0, 0, 8'h08); rd(0, 0, d); chk("ch0_chain_ro", d, 0);
`ifdef TIMER_CHAIN_EN
        wr(0, 4, 1); wr(0, 5, 0); wr(1, 4, 1); wr(1, 5, 0);
        wr(1, 0, 8'h0b);
        rd(1, 0, d); chk("ch1_chain_rb", d, 8'h0b);
        wr(0, 0, 8'h03);
        wait_pend(1, 50, k); chk("chain_first", k, 4);
        next_expiry(1, n); chk("chain_period", n, 4);
        wr(0, 0, 0); wr(1, 0, 0);
`else
        wr(1, 0, 8'h08); rd(1, 0, d); chk("ch1_chain_absent", d, 0);
        wr(1, 0, 0);
`endif
        wr(0, 1, 1); wr(1, 1, 1); step();
        chk("idle_irq", int'(irq), 0);

        // Randomized one-shot runs against (reload+1)*(presc+1).
        for (int t = 0; t < 8; t++) begin
            ch  = int'($urandom_range(CHANNELS - 1, 0));
            rl  = int'($urandom_range(12, 0));
            ps  = int'($urandom_range(5, 0));
            per = (rl + 1) * (ps + 1);
            k0  = int'($urandom_range(per - 1, 0));
            wr(ch, 4, rl); wr(ch, 5, 0);
            wr(ch, 0, (ps << 4) | 5);
            for (int i = 0; i < k0; i++) step();
            rd(ch, 8, d); chk("rnd_count", d, rl - k0 / (ps + 1));
            wait_pend(ch, per + 5, k); chk("rnd_period", k0 + k, per);
            step(); chk("rnd_irq", int'(irq), 1);
            rd(ch, 0, d); chk("rnd_ctrl", d, (ps << 4) | 4);
            wr(ch, 1, 1);
            step(); chk("rnd_irq_clr", int'(irq), 0);
        end

        // Reset mid-count wipes everything.
        wr(0, 4, 0); wr(0, 5, 1); wr(0, 0, 8'h07);
        step(); step(); step();
        reset = 1'b1; step(); reset = 1'b0;
        chk("mid_rst_irq", int'(irq), 0);
        rd(0, 0, d); chk("mid_rst_ctrl", d, 0);
        rd(0, 1, d); chk("mid_rst_stat", d, 0);
        rd(0, 5, d); chk("mid_rst_rl1", d, 8'hff);
        rd_count(0, d); chk("mid_rst_count", d, 16'hffff);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/timer_multi.md
Name: timer_multi

Overview:
- Parametrised successor to the single 16-bit down-counter timer: CHANNELS independent down-counters of WIDTH bits on the CPU's 8-bit memory-mapped bus.
- Each channel adds:
  - a per-channel 4-bit prescaler;
  - one-shot or periodic mode;
  - atomic multi-byte reload commit;
  - tear-free multi-byte count reads;
  - a sticky, write-1-to-clear interrupt flag.
- A single combined interrupt line goes to the CPU interrupt controller.

Parameters:
- WIDTH, 16: counter width in bits. Must be a multiple of 8, range 8..32.
- CHANNELS, 2: number of timer channels, range 1..8.

Ports:
- clk, input, 1: system clock. All logic is on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- addr, input, $clog2(CHANNELS)+4: register address. addr[3:0] is the offset; the upper bits select the channel.
- wdata, input, 8: write data.
- we, input, 1: write strobe, one access per cycle.
- re, input, 1: read strobe. Used only for the count snapshot; rdata is valid regardless of re.
- rdata, output, 8: combinational read data for the current addr.
- irq, output, 1: registered OR over all channels of (pending & int_en).

Behaviour:
- Register map per channel:
  - 0x0 CTRL: bit0 en, bit1 periodic, bit2 int_en, bit3 chain, bits7:4 presc.
  - 0x1 STAT: bit0 pending. Writing 1 clears it; other bits read 0.
  - 0x4-0x7 RELOAD bytes 0..3.
  - 0x8-0xB COUNT bytes 0..3, read-only.
  - All other offsets, and bytes at or above WIDTH/8, read 0 and ignore writes. Channel index >= CHANNELS reads 0.
- Reset: all CTRL/STAT 0, reload all-ones, count all-ones, shadow 0, snapshot 0, prescaler 0, irq 0.
- Reload commit:
  - Byte writes go to a per-channel shadow register.
  - Writing the top byte (offset 0x4+WIDTH/8-1) copies the full shadow into reload on that clock edge.
  - A running count is unaffected until its next reload.
- Start:
  - A CTRL write that takes en from 0 to 1 loads count <= reload (the committed value, including a commit in the same cycle) and clears the prescaler.
  - Writing en=1 while already 1 does not reload.
  - Writing en=0 freezes count and prescaler.
- Tick, when en=1:
  - The prescaler counts 0..presc. A tick fires in the cycle the prescaler equals presc, and the prescaler then wraps to 0.
  - Period is presc+1 cycles; presc=0 ticks every cycle.
- On a tick:
  - If count != 0: count <= count-1.
  - If count == 0: pending <= 1. Then:
    - periodic=1: count <= reload.
    - periodic=0: en <= 0 and count stays 0 (one-shot).
  - The expiry period is therefore (reload+1)*(presc+1) cycles. Reload 0 in periodic mode sets pending on every tick.
- Interrupt:
  - irq is registered, so it rises 1 cycle after pending&int_en becomes true.
  - It stays high until every contributing pending bit is cleared or masked.
  - If a W1C clear and a new expiry land on the same cycle, set wins.
- Count snapshot:
  - A cycle with re=1 at COUNT byte 0 latches the full live count into the channel snapshot.
  - Byte 0 reads live count[7:0]; bytes 1..3 read the snapshot.
  - Software reads byte 0 first for a coherent value.
- Writes to CTRL in the same cycle as a tick: the write is applied and the tick's count update still happens, except on an en 1->0 write, which suppresses the tick.
- A reset mid-count aborts everything on that edge; no pending bit survives.

Optional Feature:
- Macro: TIMER_CHAIN_EN.
- Defined: for a channel c>0 with chain=1, the tick source is channel c-1's expiry event instead of its own prescaler. presc is ignored. This cascades channels into wider counters. The chain bit on channel 0 reads 0 and is ignored.
- Undefined: the chain bit is not implemented, reads 0, writes are ignored, and all channels use their own prescaler.

Test Plan:
- Reset, then read every register → CTRL/STAT=0x00, RELOAD bytes 0xFF, COUNT bytes 0xFF, irq=0.
- Ch0: write RELOAD=0x0003, CTRL=0x07 (presc 0, int_en, periodic, en) → pending set every 4 cycles; irq rises 1 cycle after pending. W1C STAT → irq drops, then re-asserts on the next expiry.
- Ch1: write RELOAD=0x0002, CTRL=0x25 (presc 2, one-shot, int_en) → pending after 9 cycles; en reads 0; COUNT stays 0x0000 thereafter.
- Write RELOAD low=0x10 only while running with reload 0x0003 → period unchanged. Write high=0x00 → next reload uses 0x0010.
- While count=0x0100 decrementing every cycle: read COUNT byte0 (re=1), then byte1 a few cycles later → byte1 returns 0x01 from the snapshot, not the live value.
- With TIMER_CHAIN_EN: ch0 reload 1 periodic, ch1 reload 1 chain periodic → ch1 pending every 4 cycles. Without the macro: the chain bit reads back 0.
